// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_PKT_LOCK_EN to hold the grant on one requester until req_last.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_transmit,
    output logic [7:0]           uart_tx_byte,
    input  logic                 uart_is_transmitting,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] rr_winner;
    logic [IDW-1:0] winner;
    logic           rr_found;
    logic           found;
    logic           grant;
    int unsigned    scan_idx;
    logic [7:0]     req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(ptr) + k) % NUM_REQ;
            if (!rr_found && req_valid[IDW'(scan_idx)]) begin
                rr_found  = 1'b1;
                rr_winner = IDW'(scan_idx);
            end
        end
    end

`ifdef UART_ARB_PKT_LOCK_EN
    logic           lock;
    logic [IDW-1:0] lock_id;

    always_comb begin
        found  = rr_found;
        winner = rr_winner;
        if (lock) begin
            found  = req_valid[lock_id];
            winner = lock_id;
        end
    end

    // req_last is captured with the byte, so it reflects the accepted byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock    <= 1'b0;
            lock_id <= '0;
        end else if (grant) begin
            lock    <= !req_last[winner];
            lock_id <= winner;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign found       = rr_found;
    assign winner      = rr_winner;
`endif

    assign grant = (state == IDLE) && found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        uart_transmit = 1'b0;
        req_ready     = '0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                uart_transmit       = 1'b1;
                req_ready[grant_id] = 1'b1;
                state_next          = WAIT_START;
            end
            WAIT_START: begin
                if (uart_is_transmitting) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_tx_byte <= '0;
            grant_id     <= '0;
            ptr          <= '0;
        end else if (grant) begin
            uart_tx_byte <= req_bytes[winner];
            grant_id     <= winner;
            ptr          <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small serial UART transmitter model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;
    localparam int BITP    = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_transmit;
    logic [7:0]           uart_tx_byte;
    logic                 uart_is_transmitting;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_data             (req_data),
        .req_last             (req_last),
        .req_ready            (req_ready),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .grant_id             (grant_id),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    // UART model: 8N1, BITP clocks per bit, ignores transmit while busy.
    logic       is_tx = 1'b0;
    logic [9:0] shreg = '1;
    int         phase = 0;
    int         bitcnt = 0;
    logic       uart_line;

    always @(posedge clk) begin
        if (!is_tx) begin
            if (uart_transmit) begin
                shreg  <= {1'b1, uart_tx_byte, 1'b0};
                is_tx  <= 1'b1;
                phase  <= 0;
                bitcnt <= 0;
            end
        end else if (phase == BITP - 1) begin
            phase <= 0;
            shreg <= {1'b1, shreg[9:1]};
            if (bitcnt == 9) is_tx <= 1'b0;
            else bitcnt <= bitcnt + 1;
        end else begin
            phase <= phase + 1;
        end
    end

    assign uart_is_transmitting = is_tx;
    assign uart_line            = is_tx ? shreg[0] : 1'b1;

    always @(negedge clk) begin
        if (uart_transmit && uart_is_transmitting) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_tx(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_transmit) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !uart_is_transmitting) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_settle"}, 32'(ok), 32'd1);
    endtask

    task automatic expect_grant(input string tag, input int id, input logic [7:0] b);
        bit ok;
        wait_tx(ok);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_id"}, 32'(grant_id), 32'(id));
            check({tag, "_byte"}, 32'(uart_tx_byte), 32'(b));
            check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
        end
        @(negedge clk);
        check({tag, "_pulse"}, 32'({uart_transmit, req_ready}), 32'd0);
    endtask

    task automatic rx_byte(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!uart_line) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            repeat (BITP + 1) @(negedge clk);
            b = {uart_line, b[7:1]};
            for (int j = 1; j < 8; j++) begin
                repeat (BITP) @(negedge clk);
                b = {uart_line, b[7:1]};
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] rxb;
        bit         rxok;
        int         exp_id [5];
        logic [7:0] exp_b [5];
        logic [7:0] r1_bytes [3];
        int         r1_idx;

        // Reset release, idle for 100 cycles.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({busy, uart_transmit, req_ready, uart_tx_byte, grant_id}), 32'd0);
        end

        // Single request from requester 2, exact launch timing and serial decode.
        req_valid[2]    = 1'b1;
        req_data[23:16] = 8'hA5;
        check("single_pre", 32'(uart_transmit), 32'd0);
        @(negedge clk);
        check("single_tx", 32'(uart_transmit), 32'd1);
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_byte", 32'(uart_tx_byte), 32'hA5);
        check("single_id", 32'(grant_id), 32'd2);
        @(negedge clk);
        req_valid = '0;
        check("single_pulse", 32'({uart_transmit, req_ready}), 32'd0);
        check("single_hold", 32'(uart_tx_byte), 32'hA5);
        rx_byte(rxb, rxok);
        check("single_rx_start", 32'(rxok), 32'd1);
        check("single_rx_byte", 32'(rxb), 32'hA5);
        settle("single");
        pulse_reset();

        // All four requesters valid: strict rotation 0,1,2,3,0,1,2,3.
        req_data  = 32'h13121110;
        req_valid = 4'hF;
        for (int g = 0; g < 8; g++) begin
            expect_grant($sformatf("rr%0d", g), g % 4, 8'(8'h10 + g % 4));
        end

        // Only 1 and 3 valid after a grant to 3: expect 1, 3, 1.
        req_valid = 4'b1010;
        expect_grant("wrap0", 1, 8'h11);
        expect_grant("wrap1", 3, 8'h13);
        expect_grant("wrap2", 1, 8'h11);
        req_valid = '0;
        settle("wrap");
        pulse_reset();

        // Requester 1 sends a 3-byte packet while requester 0 contends.
        r1_bytes = '{8'h31, 8'h32, 8'h33};
`ifdef UART_ARB_PKT_LOCK_EN
        exp_id = '{1, 1, 1, 0, 0};
        exp_b  = '{8'h31, 8'h32, 8'h33, 8'h50, 8'h50};
`else
        exp_id = '{1, 0, 1, 0, 1};
        exp_b  = '{8'h31, 8'h50, 8'h32, 8'h50, 8'h33};
`endif
        r1_idx         = 0;
        req_data[15:8] = r1_bytes[0];
        req_last[1]    = 1'b0;
        req_valid[1]   = 1'b1;
        for (int g = 0; g < 5; g++) begin
            expect_grant($sformatf("pkt%0d", g), exp_id[g], exp_b[g]);
            if (g == 0) begin
                req_data[7:0] = 8'h50;
                req_last[0]   = 1'b1;
                req_valid[0]  = 1'b1;
            end
            if (exp_id[g] == 1) begin
                r1_idx++;
                if (r1_idx == 3) begin
                    req_valid[1] = 1'b0;
                end else begin
                    req_data[15:8] = r1_bytes[r1_idx];
                    req_last[1]    = (r1_idx == 2);
                end
            end
        end
        req_valid = '0;
        req_last  = '0;
        settle("pkt");

        // Asynchronous reset while waiting for the frame to finish.
        req_data[7:0] = 8'h77;
        req_valid[0]  = 1'b1;
        expect_grant("pre_rst", 0, 8'h77);
        req_valid = '0;
        for (int i = 0; i < 10 && !uart_is_transmitting; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("wd_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 check("async_rst", 32'({busy, uart_transmit, req_ready, uart_tx_byte, grant_id}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        settle("post_rst");
        req_data[23:16] = 8'h5C;
        req_valid[2]    = 1'b1;
        expect_grant("post_rst", 2, 8'h5C);
        req_valid = '0;
        settle("final");

        check("no_overlap", 32'(viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
